// File: rtl/gray_pkg.sv
// gray_pkg: shared mode constants, Gray helper and pipeline segment arithmetic
package gray_pkg;
  localparam logic GRAY_TO_BIN = 1'b0;
  localparam logic BIN_TO_GRAY = 1'b1;
  typedef struct packed {
    int hi;
    int lo;
  } seg_t;
  function automatic logic [63:0] bin2gray(input logic [63:0] b);
    return b ^ (b >> 1);
  endfunction
  // Bits [hi:lo] resolved by stage k; hi < 0 means the stage only passes data through.
  function automatic seg_t seg_bounds(input int width, input int stages, input int k);
    int s;
    int lo;
    s = (width + stages - 1) / stages;
    lo = width - (k + 1) * s;
    seg_bounds.hi = width - 1 - k * s;
    seg_bounds.lo = lo < 0 ? 0 : lo;
  endfunction
endpackage

// File: rtl/gray_pipe_stage.sv
// gray_pipe_stage: one register stage resolving its Gray segment, with ready/hold
module gray_pipe_stage
  import gray_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STAGES = 2,
  parameter int STAGE_IDX = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prev_valid,
  input  logic             prev_mode,
  input  logic [WIDTH-1:0] prev_data,
  input  logic             next_ready,
  output logic             ready,
  output logic             valid,
  output logic             mode,
  output logic [WIDTH-1:0] data
);
  localparam seg_t SEG = seg_bounds(WIDTH, STAGES, STAGE_IDX);
  logic [WIDTH-1:0] res;
  assign ready = !valid || next_ready;
  // Stage 0 does the whole binary->Gray; Gray->binary chains down through this segment using the resolved bit above it.
  always_comb begin
    res = prev_data;
    if (STAGE_IDX == 0 && prev_mode == BIN_TO_GRAY)
      res = WIDTH'(bin2gray(64'(prev_data)));
    else if (prev_mode == GRAY_TO_BIN)
      for (int i = WIDTH - 2; i >= 0; i--)
        if (i >= SEG.lo && i <= SEG.hi) res[i] = res[i] ^ res[i+1];
  end
  // Load from upstream whenever this stage can accept, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      mode  <= 1'b0;
      data  <= '0;
    end else if (ready) begin
      valid <= prev_valid;
      mode  <= prev_mode;
      data  <= res;
    end
  end
endmodule

// File: rtl/gray_pipe_conv.sv
// gray_pipe_conv: pipelined Gray/binary converter with per-word direction and valid/ready
module gray_pipe_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode
);
  logic [STAGES:0] v, m, r;
  logic [WIDTH-1:0] d [STAGES+1];
  assign v[0] = in_valid;
  assign m[0] = in_mode;
  assign d[0] = in_data;
  assign r[STAGES] = out_ready;
  assign in_ready = r[0];
  assign out_valid = v[STAGES];
  assign out_mode = m[STAGES];
  assign out_data = d[STAGES];
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    gray_pipe_stage #(.WIDTH(WIDTH), .STAGES(STAGES), .STAGE_IDX(k)) u_stage (
      .clk(clk),
      .rst(rst),
      .prev_valid(v[k]),
      .prev_mode(m[k]),
      .prev_data(d[k]),
      .next_ready(r[k+1]),
      .ready(r[k]),
      .valid(v[k+1]),
      .mode(m[k+1]),
      .data(d[k+1])
    );
  end
endmodule

// File: tb/tb_gray_pipe_conv.sv
// tb_gray_pipe_conv: scoreboard bench for 8/2, 5/5 and 5/1 converter instances
module tb_gray_pipe_conv;
  typedef struct {
    logic [7:0] d;
    logic m;
    int c;
  } exp_t;
  logic clk = 0, rst = 1;
  logic iv8 = 0, ir8, im8 = 0, ov8, or8 = 1, om8;
  logic [7:0] id8 = 0, od8;
  logic iv5 = 0, im5 = 0, ir5a, ir5b, ov5a, ov5b, om5a, om5b;
  logic [4:0] id5 = 0, od5a, od5b;
  int cyc = 0, nvec = 0, nfail = 0;
  exp_t q8[$], q5a[$], q5b[$];
  exp_t e8, e5a, e5b;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  gray_pipe_conv #(.WIDTH(8), .STAGES(2)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_mode(im8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_mode(om8));
  gray_pipe_conv #(.WIDTH(5), .STAGES(5)) u5a (
    .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5a), .in_data(id5), .in_mode(im5),
    .out_valid(ov5a), .out_ready(1'b1), .out_data(od5a), .out_mode(om5a));
  gray_pipe_conv #(.WIDTH(5), .STAGES(1)) u5b (
    .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5b), .in_data(id5), .in_mode(im5),
    .out_valid(ov5b), .out_ready(1'b1), .out_data(od5b), .out_mode(om5b));
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    nvec++;
    if (a !== x) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask
  function automatic logic [4:0] ref_g2b(input logic [4:0] g);
    for (int i = 0; i < 5; i++) ref_g2b[i] = ^(g >> i);
  endfunction
  function automatic logic [4:0] ref_b2g(input logic [4:0] b);
    return b ^ {1'b0, b[4:1]};
  endfunction
  task automatic send8(input logic [7:0] d, input logic m, input logic [7:0] e, input bit lat);
    int n = 0;
    iv8 = 1; id8 = d; im8 = m;
    @(negedge clk);
    while (!ir8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ir8) begin
      nvec++; nfail++;
      $display("FAIL send8_timeout: in_ready stuck at %b, required 1", ir8);
    end else q8.push_back('{e, m, lat ? cyc : -1});
    @(posedge clk); #1;
  endtask
  task automatic send5(input logic [4:0] d, input logic m, input logic [4:0] e);
    int n = 0;
    iv5 = 1; id5 = d; im5 = m;
    @(negedge clk);
    while (!(ir5a && ir5b) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(ir5a && ir5b)) begin
      nvec++; nfail++;
      $display("FAIL send5_timeout: in_ready %b%b, required 11", ir5a, ir5b);
    end else begin
      q5a.push_back('{{3'b0, e}, m, cyc});
      q5b.push_back('{{3'b0, e}, m, cyc});
    end
    @(posedge clk); #1;
  endtask
  always @(negedge clk) if (!rst && ov8 && or8) begin
    if (q8.size() == 0) begin
      nvec++; nfail++;
      $display("FAIL out8_unexpected: got %0h with nothing outstanding", od8);
    end else begin
      e8 = q8.pop_front();
      chk("out8_data", od8, e8.d);
      chk("out8_mode", om8, e8.m);
      if (e8.c >= 0) chk("out8_latency", cyc - e8.c, 2);
    end
  end
  always @(negedge clk) if (!rst && ov5a) begin
    if (q5a.size() == 0) begin
      nvec++; nfail++;
      $display("FAIL out5s5_unexpected: got %0h with nothing outstanding", od5a);
    end else begin
      e5a = q5a.pop_front();
      chk("out5s5_data", od5a, e5a.d[4:0]);
      chk("out5s5_mode", om5a, e5a.m);
      chk("out5s5_latency", cyc - e5a.c, 5);
    end
  end
  always @(negedge clk) if (!rst && ov5b) begin
    if (q5b.size() == 0) begin
      nvec++; nfail++;
      $display("FAIL out5s1_unexpected: got %0h with nothing outstanding", od5b);
    end else begin
      e5b = q5b.pop_front();
      chk("out5s1_data", od5b, e5b.d[4:0]);
      chk("out5s1_mode", om5b, e5b.m);
      chk("out5s1_latency", cyc - e5b.c, 1);
    end
  end
  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", ov8, 0);
    chk("rst_out_data", od8, 0);
    chk("rst_out_mode", om8, 0);
    chk("rst_in_ready", {ir8, ir5a, ir5b}, 3'b111);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", ir8, 1);
    @(posedge clk); #1;
    send8(8'hC0, 0, 8'h80, 1);
    send8(8'h80, 0, 8'hFF, 1);
    send8(8'h2D, 1, 8'h3B, 1);
    send8(8'h3B, 0, 8'h2D, 1);
    send8(8'h05, 1, 8'h07, 1);
    send8(8'h07, 0, 8'h05, 1);
    send8(8'hFF, 1, 8'h80, 1);
    send8(8'hFF, 0, 8'hAA, 1);
    iv8 = 0;
    repeat (4) @(posedge clk); #1;
    or8 = 0;
    send8(8'h01, 1, 8'h01, 0);
    send8(8'h02, 1, 8'h03, 0);
    id8 = 8'h03; im8 = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_in_ready", ir8, 0);
      chk("stall_valid", ov8, 1);
      chk("stall_data", {om8, od8}, {1'b1, 8'h01});
    end
    @(posedge clk); #1 or8 = 1;
    send8(8'h03, 1, 8'h02, 0);
    iv8 = 0;
    repeat (4) @(posedge clk); #1;
    send8(8'h11, 1, 8'h19, 0);
    send8(8'h22, 1, 8'h33, 0);
    iv8 = 0;
    rst = 1;
    #1;
    chk("midrst_out_valid", ov8, 0);
    chk("midrst_out_data", od8, 0);
    chk("midrst_in_ready", ir8, 1);
    q8.delete();
    repeat (2) @(posedge clk); #1 rst = 0;
    repeat (5) @(negedge clk);
    chk("after_rst_in_ready", ir8, 1);
    @(posedge clk); #1;
    send8(8'hC0, 0, 8'h80, 1);
    iv8 = 0;
    for (int m = 0; m < 2; m++)
      for (int v = 0; v < 32; v++)
        send5(5'(v), m[0], m[0] ? ref_b2g(5'(v)) : ref_g2b(5'(v)));
    iv5 = 0;
    n = 0;
    while ((q8.size() + q5a.size() + q5b.size()) != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_outstanding", q8.size() + q5a.size() + q5b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/gray_pipe_conv.md
# gray_pipe_conv

Parametrised, pipelined Gray/binary code converter with valid/ready handshakes on both sides. Each transaction carries its own direction (Gray→binary or binary→Gray). The Gray→binary prefix-XOR chain is split across `STAGES` register stages so wide words meet timing. The block sits between pointer/counter logic and consumers such as async-FIFO pointer synchronisers and position encoders, and generalises the team's fixed 4-bit combinational Gray decoder.

## Interface
- `WIDTH`, default 8: data width in bits; legal range 2..64.
- `STAGES`, default 2: pipeline depth; legal range 1..WIDTH.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block accepts the word this cycle.
- `in_data`  in  WIDTH  word to convert.
- `in_mode`  in  1  0 = Gray→binary, 1 = binary→Gray.
- `out_valid`  out  1  converted word present.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  WIDTH  converted word.
- `out_mode`  out  1  `in_mode` of the word, carried alongside it.

## Operation
- **Transfer rule.** A transfer occurs on any edge where valid && ready on that side.
- **Pipeline structure.** `STAGES` register stages, each holding {valid, mode, partial data}.
- **Segments.** Segment size S = ceil(WIDTH/STAGES). Stage k (k = 0 first) resolves bits [WIDTH-1-k·S : max(0, WIDTH-(k+1)·S)], MSB first.
- **Gray→binary.** b[WIDTH-1] = g[WIDTH-1]; b[i] = g[i] ^ b[i+1].
  - Each stage resolves its segment using the already-resolved bit above the segment.
  - Unresolved bits travel unchanged as raw Gray.
- **Binary→Gray.** g = b ^ (b >> 1), computed entirely in stage 0. Later stages pass the word through untouched.
- **Mode carry.** Mode travels with the data; words of different modes may be interleaved back-to-back.
- **Stage ready.** ready_k = !valid_k || ready_{k+1}, with ready_STAGES = `out_ready`.
  - `in_ready` = ready_0.
  - The ready path is combinational back-to-front. No skid buffer.
- **Stage update.** When ready_k, stage k loads from stage k-1 (or the input for k = 0), including the valid bit. Otherwise it holds.
- **Outputs.** `out_valid`, `out_data` and `out_mode` come directly from the last stage's registers.
- **Stall stability.** While `out_valid` && !`out_ready`, `out_data` and `out_mode` hold stable.
- **No state machine.** Behaviour is purely the per-stage valid/occupancy pipeline.

## Timing
- **Latency.** Exactly `STAGES` cycles from input transfer to `out_valid`, with no backpressure.
- **Throughput.** One word per cycle while `out_ready` is high.
- **Reset.** All stage valid bits = 0, data = 0, mode = 0. Therefore `out_valid` = 0, `out_data` = 0, `out_mode` = 0, and `in_ready` = 1 while in reset and after reset release.
- **Reset mid-operation.** In-flight words are discarded and no partial word is emitted. The first input transfer after reset release takes `STAGES` cycles to reach the output.
- **Full pipeline.** All stages valid and `out_ready` = 0 gives `in_ready` = 0 in the same cycle. `in_valid` is ignored while `in_ready` = 0.
- **Simultaneous events.** Output transfer and input transfer in the same cycle on a full pipeline: both occur and occupancy is unchanged.
- **STAGES = 1.** Single register stage; the full conversion is computed in one cycle.
- **STAGES = WIDTH.** One bit is resolved per stage.
- **Last segment.** It may be shorter than S. Stages beyond the LSB segment, if ceil rounding leaves any, pass data through.

## Structure
- Shared package `gray_pkg`:
  - mode constants `GRAY_TO_BIN` = 1'b0, `BIN_TO_GRAY` = 1'b1;
  - function `bin2gray(WIDTH)`;
  - function computing segment bounds from (WIDTH, STAGES, k).
- Sub-module `gray_pipe_stage`:
  - one register stage;
  - parameters WIDTH, STAGES, STAGE_IDX;
  - handles its own segment resolve, ready_k generation and hold.
- Top-level `gray_pipe_conv` instantiates `STAGES` copies in a generate loop and wires the ready chain.

## Test plan
- **Gray→binary streaming.** WIDTH = 8, STAGES = 2, `out_ready` = 1; send Gray 8'hC0 then 8'h80. Required: 8'h80 then 8'hFF, at cycles +2 and +3, `out_mode` = 0.
- **Binary→Gray and round-trip.** Send binary 8'h2D (mode 1). Required: 8'h3B. Feeding 8'h3B back with mode 0 returns 8'h2D.
- **Backpressure.** Hold `out_ready` = 0 and push 3 words. Required:
  - `in_ready` drops after 2 accepts;
  - `out_data` stays stable;
  - after `out_ready` rises, words exit in order with none lost or duplicated.
- **Interleaved modes.** Send alternating-mode words back-to-back. Required: each output matches its own mode, and `out_mode` tracks them.
- **Reset mid-operation.** Assert `rst` with 2 words in flight. Required: `out_valid` = 0 immediately (asynchronous), no stale word after release, `in_ready` = 1.
- **Exhaustive sweep.** WIDTH = 5, STAGES = 5 and STAGES = 1; all 32 codes in both modes. Required: matches reference functions and latency = STAGES.
